mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 8:1 n-bit func_mux between 8 requesters.
//  It samples request lines and grants exactly one requester at a time.
//  It drives the mux select and a one-hot grant, and enforces a bounded hold time.

---
 rtl/soda_pkg.sv | 12 +
 rtl/rr_pick.sv | 41 ++++
 rtl/mux_rr_arbiter.sv | 101 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/soda_pkg.sv
// rtl/soda_pkg.sv - shared soda-machine datapath constants and arbiter state encoding
package soda_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner pick over 8 requesters
//
// Ports:
//   req  in  [N_REQ-1:0]  request lines
//   base in  [SEL_W-1:0]  highest-priority index for this pick
//   any  out              at least one request is set
//   idx  out [SEL_W-1:0]  winning index (first set bit scanning base, base+1, ... mod 8)
module rr_pick
    import soda_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] base,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;

    // Doubling the vector turns the right-rotate into a plain shift.
    always_comb begin
        dbl = {req, req} >> base;
        rot = dbl[N_REQ-1:0];
    end

    // Lowest set bit of the rotated vector; scanning downwards lets the
    // lowest index overwrite higher ones.
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = base + off;

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter sharing one 8:1 func_mux with bounded hold
//
// Ports:
//   clk      in        rising-edge clock
//   rst_n    in        asynchronous active-low reset
//   req      in  [7:0] per-requester request; req[i] maps to mux input x_i
//   done     in  [7:0] release strobe; only done[sel] is honoured while granted
//   sel      out [2:0] registered mux select, drives func_mux.sel
//   gnt      out [7:0] registered one-hot grant, zero when idle
//   busy     out       high while a grant is held
//   timeout  out       one-cycle pulse when a grant is force-released at MAX_HOLD
module mux_rr_arbiter
    import soda_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             timeout
);

    arb_state_t       state, state_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [SEL_W-1:0] sel_n;
    logic [N_REQ-1:0] gnt_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic             timeout_n;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;

    rr_pick u_pick (
        .req  (req),
        .base (ptr),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            sel      <= '0;
            gnt      <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            sel      <= sel_n;
            gnt      <= gnt_n;
            hold_cnt <= hold_n;
            timeout  <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        sel_n     = sel;
        gnt_n     = gnt;
        hold_n    = hold_cnt;
        timeout_n = 1'b0;
        case (state)
            ST_IDLE: begin
                gnt_n = '0;
                if (pick_any) begin
                    state_n = ST_GRANT;
                    sel_n   = pick_idx;
                    gnt_n   = N_REQ'(1) << pick_idx;
                    hold_n  = '0;
                end
            end
            ST_GRANT: begin
                hold_n = hold_cnt + 1'b1;
                // Normal release outranks the forced one, so a done arriving
                // on the last allowed cycle never raises timeout.
                if (done[sel] || !req[sel] || (hold_cnt == HOLD_W'(MAX_HOLD - 1))) begin
                    timeout_n = !(done[sel] || !req[sel]);
                    state_n   = ST_IDLE;
                    gnt_n     = '0;
                    ptr_n     = sel + 3'd1;
                    hold_n    = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    assign busy = (state == ST_GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking scoreboard bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] done;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] gnt;
        logic       timeout;
    } exp_t;

    exp_t sb[$];

    mux_rr_arbiter #(.MAX_HOLD(15), .HOLD_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Holds reset across one edge with the given request pattern, then
    // releases it away from the edge; the next edge is the first arbitration.
    task automatic do_reset(input logic [7:0] r);
        rst_n = 1'b0;
        req   = r;
        done  = 8'h00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        req   = 8'hFF;
        done  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sel !== 3'd0 || gnt !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: sel=%0d gnt=%h busy=%b timeout=%b, required sel=0 gnt=00 busy=0 timeout=0",
                     sel, gnt, busy, timeout);
        end
        rst_n = 1'b1;
        sb.push_back('{gnt: 8'h01, timeout: 1'b0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (gnt !== e.gnt || busy !== 1'b1 || sel !== 3'd0) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%h busy=%b sel=%0d, required gnt=%h busy=1 sel=0",
                     gnt, busy, sel, e.gnt);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        do_reset(8'hFF);
        for (int k = 0; k < 9; k++) begin
            sb.push_back('{gnt: 8'h01 << (k % 8), timeout: 1'b0});
            sb.push_back('{gnt: 8'h00, timeout: 1'b0});
        end
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || timeout !== e.timeout || busy !== (e.gnt != 8'h00)) begin
                errors++;
                $display("FAIL round_robin: gnt=%h timeout=%b busy=%b, required gnt=%h timeout=%b",
                         gnt, timeout, busy, e.gnt, e.timeout);
            end
            done = e.gnt;
        end
        done = 8'h00;
    endtask

    task automatic test_skip_wrap();
        exp_t e;
        int   step;
        do_reset(8'h20);
        sb.push_back('{gnt: 8'h20, timeout: 1'b0});
        sb.push_back('{gnt: 8'h00, timeout: 1'b0});
        sb.push_back('{gnt: 8'h01, timeout: 1'b0});
        sb.push_back('{gnt: 8'h00, timeout: 1'b0});
        sb.push_back('{gnt: 8'h04, timeout: 1'b0});
        step = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt) begin
                errors++;
                $display("FAIL skip_wrap step %0d: gnt=%h, required %h", step, gnt, e.gnt);
            end
            done = e.gnt;
            if (step == 1) req = 8'h05;
            step++;
        end
        done = 8'h00;
    endtask

    task automatic test_timeout();
        exp_t e;
        int   step;
        do_reset(8'h08);
        for (int k = 0; k < 15; k++) sb.push_back('{gnt: 8'h08, timeout: 1'b0});
        sb.push_back('{gnt: 8'h00, timeout: 1'b1});
        sb.push_back('{gnt: 8'h08, timeout: 1'b0});
        step = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || timeout !== e.timeout) begin
                errors++;
                $display("FAIL timeout step %0d: gnt=%h timeout=%b, required gnt=%h timeout=%b",
                         step, gnt, timeout, e.gnt, e.timeout);
            end
            step++;
        end
    endtask

    task automatic test_foreign_done();
        exp_t e;
        int   step;
        do_reset(8'h02);
        sb.push_back('{gnt: 8'h02, timeout: 1'b0});
        sb.push_back('{gnt: 8'h02, timeout: 1'b0});
        sb.push_back('{gnt: 8'h00, timeout: 1'b0});
        step = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || timeout !== e.timeout || sel !== 3'd1) begin
                errors++;
                $display("FAIL foreign_done step %0d: gnt=%h timeout=%b sel=%0d, required gnt=%h timeout=%b sel=1",
                         step, gnt, timeout, sel, e.gnt, e.timeout);
            end
            if (step == 0) begin
                done = 8'h20;
            end else if (step == 1) begin
                done = 8'h00;
                req  = 8'h00;
            end
            step++;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset(8'h10);
        sb.push_back('{gnt: 8'h10, timeout: 1'b0});
        sb.push_back('{gnt: 8'h00, timeout: 1'b0});
        sb.push_back('{gnt: 8'h10, timeout: 1'b0});
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt) begin
                errors++;
                $display("FAIL async_setup: gnt=%h, required %h", gnt, e.gnt);
            end
            done = (sb.size() == 2) ? 8'h10 : 8'h00;
        end
        // Grant to idx4 is live with ptr=5; drop reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_immediate: gnt=%h busy=%b, required gnt=00 busy=0", gnt, busy);
        end
        // With ptr back at 0, req 0x11 must go to idx0 rather than idx4.
        req = 8'h11;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            errors++;
            $display("FAIL async_reset_ptr: gnt=%h sel=%0d, required gnt=01 sel=0", gnt, sel);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 8'h00;
        test_reset();
        test_round_robin();
        test_skip_wrap();
        test_timeout();
        test_foreign_done();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
